// File: rtl/traffic_light_4way.sv
// Moore controller for a 4-way, 2-lane left-hand-traffic intersection.
// Twelve phases: N/S straight, staggered N/S right turns, then the E/W mirror.
module traffic_light_4way #(
  parameter int unsigned T_STRAIGHT = 8,
  parameter int unsigned T_YELLOW   = 2,
  parameter int unsigned T_TURN     = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] north_light,
  output logic       north_left_arrow,
  output logic       north_right_arrow,
  output logic [2:0] south_light,
  output logic       south_left_arrow,
  output logic       south_right_arrow,
  output logic [2:0] east_light,
  output logic       east_left_arrow,
  output logic       east_right_arrow,
  output logic [2:0] west_light,
  output logic       west_left_arrow,
  output logic       west_right_arrow
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef enum logic [3:0] {
    NS_STRAIGHT  = 4'd0,
    S_STOPPING   = 4'd1,
    N_RIGHT_TURN = 4'd2,
    N_STOPPING   = 4'd3,
    S_RIGHT_TURN = 4'd4,
    S_YELLOW_NEW = 4'd5,
    EW_STRAIGHT  = 4'd6,
    W_STOPPING   = 4'd7,
    E_RIGHT_TURN = 4'd8,
    E_STOPPING   = 4'd9,
    W_RIGHT_TURN = 4'd10,
    W_YELLOW_NEW = 4'd11
  } state_t;

  state_t     state, state_d;
  logic [3:0] counter, counter_d;
  state_t     nxt;
  logic [4:0] dur;
  logic       legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= NS_STRAIGHT;
      counter <= 4'd0;
    end else begin
      state   <= state_d;
      counter <= counter_d;
    end
  end

  always_comb begin
    dur               = 5'd1;
    nxt               = NS_STRAIGHT;
    legal             = 1'b1;
    north_light       = RED;
    south_light       = RED;
    east_light        = RED;
    west_light        = RED;
    north_right_arrow = 1'b0;
    south_right_arrow = 1'b0;
    east_right_arrow  = 1'b0;
    west_right_arrow  = 1'b0;
    case (state)
      NS_STRAIGHT:  begin dur = 5'(T_STRAIGHT); nxt = S_STOPPING;
                          north_light = GRN; south_light = GRN; end
      S_STOPPING:   begin dur = 5'(T_YELLOW); nxt = N_RIGHT_TURN;
                          north_light = GRN; south_light = YEL; end
      N_RIGHT_TURN: begin dur = 5'(T_TURN); nxt = N_STOPPING;
                          north_light = GRN; north_right_arrow = 1'b1; end
      N_STOPPING:   begin dur = 5'(T_YELLOW); nxt = S_RIGHT_TURN;
                          north_light = YEL; end
      S_RIGHT_TURN: begin dur = 5'(T_TURN); nxt = S_YELLOW_NEW;
                          south_light = GRN; south_right_arrow = 1'b1; end
      S_YELLOW_NEW: begin dur = 5'(T_YELLOW); nxt = EW_STRAIGHT;
                          south_light = YEL; end
      EW_STRAIGHT:  begin dur = 5'(T_STRAIGHT); nxt = W_STOPPING;
                          east_light = GRN; west_light = GRN; end
      W_STOPPING:   begin dur = 5'(T_YELLOW); nxt = E_RIGHT_TURN;
                          east_light = GRN; west_light = YEL; end
      E_RIGHT_TURN: begin dur = 5'(T_TURN); nxt = E_STOPPING;
                          east_light = GRN; east_right_arrow = 1'b1; end
      E_STOPPING:   begin dur = 5'(T_YELLOW); nxt = W_RIGHT_TURN;
                          east_light = YEL; end
      W_RIGHT_TURN: begin dur = 5'(T_TURN); nxt = W_YELLOW_NEW;
                          west_light = GRN; west_right_arrow = 1'b1; end
      W_YELLOW_NEW: begin dur = 5'(T_YELLOW); nxt = NS_STRAIGHT;
                          west_light = YEL; end
      default:      legal = 1'b0;
    endcase

    // Unreachable encodings recover to NS_STRAIGHT on the very next edge.
    if (!legal || ({1'b0, counter} == dur - 5'd1)) begin
      state_d   = nxt;
      counter_d = 4'd0;
    end else begin
      state_d   = state;
      counter_d = counter + 4'd1;
    end
  end

  // In left-hand traffic the left turn is kerbside, so it follows the green.
  assign north_left_arrow = (north_light == GRN);
  assign south_left_arrow = (south_light == GRN);
  assign east_left_arrow  = (east_light  == GRN);
  assign west_left_arrow  = (west_light  == GRN);

endmodule

// File: tb/tb_traffic_light_4way.sv
// Bench for traffic_light_4way: reference model feeds an expected queue, safety
// invariants and phase durations checked every cycle.
module tb_traffic_light_4way;

  logic       clk;
  logic       reset;
  logic [2:0] north_light, south_light, east_light, west_light;
  logic       north_left_arrow, north_right_arrow;
  logic       south_left_arrow, south_right_arrow;
  logic       east_left_arrow, east_right_arrow;
  logic       west_left_arrow, west_right_arrow;

  traffic_light_4way dut (
    .clk               (clk),
    .reset             (reset),
    .north_light       (north_light),
    .north_left_arrow  (north_left_arrow),
    .north_right_arrow (north_right_arrow),
    .south_light       (south_light),
    .south_left_arrow  (south_left_arrow),
    .south_right_arrow (south_right_arrow),
    .east_light        (east_light),
    .east_left_arrow   (east_left_arrow),
    .east_right_arrow  (east_right_arrow),
    .west_light        (west_light),
    .west_left_arrow   (west_left_arrow),
    .west_right_arrow  (west_right_arrow)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [27:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int m_st  = 0;
  int m_cnt = 0;
  int tracking = 0;
  int prev_st  = 0;
  int run_len  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int dur_of(input int s);
    int d[12] = '{8, 2, 4, 2, 4, 2, 8, 2, 4, 2, 4, 2};
    return d[s];
  endfunction

  // {state, counter, N,S,E,W lamps, nl,nr,sl,sr,el,er,wl,wr}
  function automatic logic [27:0] exp_vec(input int s, input int c);
    logic [11:0] lamps;
    logic [7:0]  arr;
    case (s)
      0:  lamps = {3'b001, 3'b001, 3'b100, 3'b100};
      1:  lamps = {3'b001, 3'b010, 3'b100, 3'b100};
      2:  lamps = {3'b001, 3'b100, 3'b100, 3'b100};
      3:  lamps = {3'b010, 3'b100, 3'b100, 3'b100};
      4:  lamps = {3'b100, 3'b001, 3'b100, 3'b100};
      5:  lamps = {3'b100, 3'b010, 3'b100, 3'b100};
      6:  lamps = {3'b100, 3'b100, 3'b001, 3'b001};
      7:  lamps = {3'b100, 3'b100, 3'b001, 3'b010};
      8:  lamps = {3'b100, 3'b100, 3'b001, 3'b100};
      9:  lamps = {3'b100, 3'b100, 3'b010, 3'b100};
      10: lamps = {3'b100, 3'b100, 3'b100, 3'b001};
      default: lamps = {3'b100, 3'b100, 3'b100, 3'b010};
    endcase
    arr = {lamps[11:9] == 3'b001, s == 2, lamps[8:6] == 3'b001, s == 4,
           lamps[5:3]  == 3'b001, s == 8, lamps[2:0] == 3'b001, s == 10};
    return {4'(s), 4'(c), lamps, arr};
  endfunction

  function automatic logic [27:0] dut_vec();
    return {4'(dut.state), dut.counter, north_light, south_light, east_light, west_light,
            north_left_arrow, north_right_arrow, south_left_arrow, south_right_arrow,
            east_left_arrow, east_right_arrow, west_left_arrow, west_right_arrow};
  endfunction

  task automatic safety();
    logic ns_go, ew_go;
    check("n_onehot", {31'd0, $onehot(north_light)}, 1);
    check("s_onehot", {31'd0, $onehot(south_light)}, 1);
    check("e_onehot", {31'd0, $onehot(east_light)}, 1);
    check("w_onehot", {31'd0, $onehot(west_light)}, 1);
    ns_go = (north_light != 3'b100) || (south_light != 3'b100);
    ew_go = (east_light  != 3'b100) || (west_light  != 3'b100);
    check("ns_ew_excl", {31'd0, ns_go && ew_go}, 0);
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    logic [27:0] e;
    int s;
    @(posedge clk);
    if (reset) begin
      m_st = 0; m_cnt = 0;
    end else if (m_cnt == dur_of(m_st) - 1) begin
      m_st = (m_st == 11) ? 0 : m_st + 1; m_cnt = 0;
    end else begin
      m_cnt++;
    end
    exp_q.push_back(exp_vec(m_st, m_cnt));
    @(negedge clk);
    check("sb_depth", exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("cycle", {4'd0, dut_vec()}, {4'd0, e});
    end
    safety();
    if (tracking != 0) begin
      s = int'(dut.state);
      if (s == prev_st) run_len++;
      else begin
        check("duration", run_len, dur_of(prev_st));
        check("order", s, (prev_st == 11) ? 0 : prev_st + 1);
        prev_st = s;
        run_len = 1;
      end
    end
  endtask

  task automatic reset_and_release();
    #2 reset = 1'b1;
    #1;
    check("async_state", {28'd0, 4'(dut.state)}, 0);
    check("async_cnt", {28'd0, dut.counter}, 0);
    check("rst_outputs", {4'd0, dut_vec()}, {4'd0, exp_vec(0, 0)});
    tracking = 0;
    step();
    step();
    reset = 1'b0;
    m_st = 0; m_cnt = 0;
    prev_st = 0; run_len = 1; tracking = 1;
  endtask

  task automatic first_transition();
    int edges = 0;
    do begin
      step();
      edges++;
    end while (int'(dut.state) != 1 && edges < 20);
    check("first_xfer_edges", edges, 8);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0;
    // Power-on reset
    reset_and_release();
    first_transition();
    for (int i = 0; i < 52; i++) step();

    // Mid-operation reset while in a non-zero counter phase
    for (int i = 0; i < 3; i++) step();
    check("pre_rst_busy", {31'd0, (dut.state != 0) || (dut.counter != 0)}, 1);
    @(negedge clk);
    reset_and_release();
    first_transition();
    for (int i = 0; i < 12; i++) step();

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_4way.md
Name: traffic_light_4way

Overview:
- Moore-type FSM controller for a 4-way, 2-lane intersection with left-hand traffic (LHT).
- Sequences 12 phases: North/South straight, staggered N/S right-turn phases, then the mirror-image East/West phases.
- Drives one 3-bit one-hot lamp and two turn arrows per approach.
- Standalone leaf block clocked by the system clock; no handshake with other logic.

Parameters:
- T_STRAIGHT, 8, cycles spent in each *_STRAIGHT state.
- T_YELLOW, 2, cycles spent in each stopping/yellow state.
- T_TURN, 4, cycles spent in each *_RIGHT_TURN state.
- All parameters must be in the range 1..16, because the counter is 4 bits wide.

Ports:
- clk  in  1  system clock, rising edge active
- reset  in  1  asynchronous, active-high reset
- north_light  out  3  one-hot lamp: 100 = red, 010 = yellow, 001 = green
- north_left_arrow  out  1  left-turn arrow on
- north_right_arrow  out  1  right-turn arrow on
- south_light, south_left_arrow, south_right_arrow  out  3/1/1  same encoding as north
- east_light, east_left_arrow, east_right_arrow  out  3/1/1  same encoding as north
- west_light, west_left_arrow, west_right_arrow  out  3/1/1  same encoding as north

Behaviour:
- Internal registers: state [3:0] and counter [3:0]. Keep these exact names; the verification bench probes them hierarchically.
- Reset is asynchronous and active-high. While reset is asserted: state = 0 (NS_STRAIGHT) and counter = 0.
- Outputs are combinational from state only (Moore). During reset, the outputs are therefore the NS_STRAIGHT outputs.
- Each rising clock edge with reset low:
  - If counter == duration(state) − 1, then state <= next state and counter <= 0.
  - Otherwise counter <= counter + 1.
  - Result: each state lasts exactly its duration in cycles.
- State sequence (encoding, name, duration, lamps given as N/S/E/W). Any approach not listed is red.
  - 0 NS_STRAIGHT, T_STRAIGHT: N=G, S=G. Next state 1.
  - 1 S_STOPPING, T_YELLOW: N=G, S=Y. Next state 2.
  - 2 N_RIGHT_TURN, T_TURN: N=G with right arrow, S=R. Next state 3.
  - 3 N_STOPPING, T_YELLOW: N=Y. Next state 4.
  - 4 S_RIGHT_TURN, T_TURN: S=G with right arrow. Next state 5.
  - 5 S_YELLOW_NEW, T_YELLOW: S=Y. Next state 6.
  - 6 to 11: EW_STRAIGHT, W_STOPPING, E_RIGHT_TURN, E_STOPPING, W_RIGHT_TURN, W_YELLOW_NEW. These mirror states 0 to 5, with N→E and S→W.
  - State 11 wraps to state 0.
- Left arrow of an approach = 1 exactly when that approach's lamp is green. In LHT the left turn is the kerbside turn.
- Right arrow of an approach = 1 only in that approach's own *_RIGHT_TURN state.
- Safety invariants, required in every cycle:
  - If north or south is not red, then east and west are both red, and vice versa.
  - No lamp output is ever 000.
  - Every lamp output is exactly one-hot.
- Full cycle with default parameters = 2 × (8 + 2 + 4 + 2 + 4 + 2) = 44 cycles.
- Illegal states 12 to 15 (unreachable): all four lamps red, all arrows 0, next state 0 with counter 0.
- Reset asserted mid-sequence: state and counter return to 0 immediately, without waiting for a clock edge. After release, the first transition (0→1) occurs T_STRAIGHT rising edges later.

Test Plan:
- Power-on reset: reset=1 for 2 cycles, then release → state=0, counter=0, N/S=001 with left arrows=1, E/W=100, all right arrows=0. Transition to state 1 occurs on the 8th rising edge after release.
- Full sequence: run 60 cycles after reset → states visited in order 0..11 then back to 0. Measured durations are 8, 2, 4, 2, 4, 2, 8, 2, 4, 2, 4, 2 cycles.
- Turn phases: state 2 → north_light=001, north_right_arrow=1, south_light=100. State 8 → east_light=001, east_right_arrow=1, west_light=100.
- Yellow phases: state 1 → south=010, north=001. State 5 → south=010, all others red. State 11 → west=010, all others red.
- Safety monitor, every cycle for the full run: no lamp equals 000, no lamp is non-one-hot, and NS-not-red never coincides with EW-not-red.
- Reset mid-operation at cycle ~62: assert for 2 cycles → state=0 and counter=0 asynchronously. Run 20 more cycles → normal sequence resumes from NS_STRAIGHT with correct durations.
